// File: rtl/bkg_pkg.sv
// Shared constants and types for the background tile generator.
package bkg_pkg;

  typedef enum logic [1:0] {
    PAT_STRIPE  = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_GRID    = 2'd2,
    PAT_SOLID   = 2'd3
  } pat_e;

  localparam logic [2:0] FG_RST = 3'b110;
  localparam logic [2:0] BG_RST = 3'b000;

  // Diagonal stripe: lit where (u + v) mod STRIPE_MOD == STRIPE_PHASE
  localparam int STRIPE_MOD   = 5;
  localparam int STRIPE_PHASE = 2;

endpackage

// File: rtl/bkg_tile_mask.sv
// Combinational tile pattern mask from tile-local coordinates.
module bkg_tile_mask
  import bkg_pkg::*;
#(
  parameter int TILE_LOG2 = 4
) (
  input  logic [TILE_LOG2-1:0] u,
  input  logic [TILE_LOG2-1:0] v,
  input  pat_e                 pat,
  output logic                 mask
);

  // One extra bit so the stripe sum does not wrap before the modulus.
  logic [TILE_LOG2:0] uv_sum;
  assign uv_sum = {1'b0, u} + {1'b0, v};

  always_comb begin
    mask = 1'b0;
    case (pat)
      PAT_STRIPE:  mask = ((32'(uv_sum) % STRIPE_MOD) == STRIPE_PHASE);
      PAT_CHECKER: mask = u[TILE_LOG2-1] ^ v[TILE_LOG2-1];
      PAT_GRID:    mask = (u == '0) || (v == '0);
      default:     mask = 1'b1;
    endcase
  end

endmodule

// File: rtl/bkg_tile_gen.sv
// Animated procedural background: frame-shadowed controls, per-frame scroll,
// two-stage pixel pipeline (tile coords, then mask + colour mux).
module bkg_tile_gen
  import bkg_pkg::*;
#(
  parameter int TILE_LOG2 = 4,
  parameter int COORD_W   = 10,
  parameter int COLOR_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               scroll_en,
  input  logic [3:0]         scroll_dx,
  input  logic [3:0]         scroll_dy,
  input  logic [1:0]         pat_sel,
  input  logic [COLOR_W-1:0] fg_col,
  input  logic [COLOR_W-1:0] bg_col,
  output logic [COLOR_W-1:0] col,
  output logic               col_valid
);

  localparam int STAGES = 2;

  typedef struct packed {
    pat_e                 pat;
    logic [COLOR_W-1:0]   fg;
    logic [COLOR_W-1:0]   bg;
    logic [TILE_LOG2-1:0] u;
    logic [TILE_LOG2-1:0] v;
  } s1_t;

  pat_e                 pat_q;
  logic [COLOR_W-1:0]   fg_q, bg_q;
  logic [TILE_LOG2-1:0] sx, sy;
  logic [STAGES:1]      vld_pipe;
  s1_t                  s1;
  logic                 mask;

  // Steps are 4-bit signed; extend to 8 then keep the low bits for mod-T add.
  logic [7:0] dx_ext, dy_ext;
  assign dx_ext = {{4{scroll_dx[3]}}, scroll_dx};
  assign dy_ext = {{4{scroll_dy[3]}}, scroll_dy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_STRIPE;
      fg_q  <= COLOR_W'(FG_RST);
      bg_q  <= COLOR_W'(BG_RST);
      sx    <= '0;
      sy    <= '0;
    end else if (frame_start) begin
      pat_q <= pat_e'(pat_sel);
      fg_q  <= fg_col;
      bg_q  <= bg_col;
      if (scroll_en) begin
        sx <= sx + dx_ext[TILE_LOG2-1:0];
        sy <= sy + dy_ext[TILE_LOG2-1:0];
      end
    end
  end

  // Stage 1 snapshots the shadow state so later frame updates cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      s1.pat   <= pat_q;
      s1.fg    <= fg_q;
      s1.bg    <= bg_q;
      s1.u     <= px[TILE_LOG2-1:0] + sx;
      s1.v     <= py[TILE_LOG2-1:0] + sy;
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
    end
  end

  bkg_tile_mask #(.TILE_LOG2(TILE_LOG2)) u_mask (
    .u    (s1.u),
    .v    (s1.v),
    .pat  (s1.pat),
    .mask (mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col <= '0;
    else        col <= vld_pipe[1] ? (mask ? s1.fg : s1.bg) : '0;
  end

  assign col_valid = vld_pipe[STAGES];

endmodule

// File: doc/bkg_tile_gen.md
# bkg_tile_gen

Parametrised, animated background tile generator for the VGA pixel path. For each active pixel coordinate it produces a COLOR_W-bit colour from a selectable procedural tile pattern, a foreground/background colour pair and a per-frame scroll offset. All control inputs are shadowed at frame boundaries. Output is registered with fixed latency. It sits between the VGA timing generator and the sprite/overlay mixer.

## Interface
- TILE_LOG2, 4, log2 of square tile edge T = 2^TILE_LOG2; legal range 3..6
- COORD_W, 10, width of px/py
- COLOR_W, 3, output colour width
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- px, py  in  COORD_W  current pixel coordinate
- pix_valid  in  1  coordinate is in active video
- frame_start  in  1  one-cycle strobe, first cycle of a frame
- scroll_en  in  1  apply scroll step at frame_start
- scroll_dx, scroll_dy  in  4  signed two's-complement step per frame (-8..+7)
- pat_sel  in  2  requested pattern, shadowed at frame_start
- fg_col, bg_col  in  COLOR_W  requested colours, shadowed at frame_start
- col  out  COLOR_W  pixel colour
- col_valid  out  1  col corresponds to a valid input pixel

## Operation
- Shadow registers: pat_q, fg_q, bg_q load pat_sel, fg_col, bg_col only in a cycle with frame_start=1. Values take effect for pixels presented from the next cycle on.
- Scroll registers: sx, sy, TILE_LOG2 bits each. On frame_start with scroll_en=1: sx <= sx + sign_extend(scroll_dx) mod T; same for sy. There is no update otherwise.
- Tile-local coordinates: u = (px + sx) mod T, v = (py + sy) mod T. Truncate to TILE_LOG2 bits; wrap is natural.
- Mask per pat_q:
  - 0 STRIPE: (u + v) mod 5 == 2
  - 1 CHECKER: u[TILE_LOG2-1] ^ v[TILE_LOG2-1]
  - 2 GRID: u == 0 or v == 0
  - 3 SOLID: 1
- col = mask ? fg_q : bg_q when the pixel is valid. Otherwise col = 0 (blanking).
- Simultaneous frame_start and pix_valid: that pixel uses the pre-update sx/sy/pat_q/fg_q/bg_q.
- Reset values: sx = sy = 0, pat_q = STRIPE, fg_q = 3'b110 (zero-extended/truncated to COLOR_W), bg_q = 0, col = 0, col_valid = 0, and all pipeline valids are 0.
- Reset asserted mid-frame: outputs go to 0 immediately. In-flight pixels are discarded. Operation resumes on the first pixel after release.

## Timing
- Two-stage pipeline, latency exactly 2 cycles from px/py/pix_valid to col/col_valid. Throughput is one pixel per cycle with no stalls.
- Stage 1 registers u, v, pixel valid and a snapshot of pat_q/fg_q/bg_q.
- Stage 2 registers the mask lookup, the colour mux, col and col_valid.
- Shadow or scroll updates caused by frame_start at cycle n never affect pixels already in stage 1 or stage 2.
- col_valid is a 2-cycle delayed copy of pix_valid.

## Structure
- Package bkg_pkg holds:
  - pattern codes PAT_STRIPE = 0, PAT_CHECKER = 1, PAT_GRID = 2, PAT_SOLID = 3
  - the reset colour constants FG_RST and BG_RST
  - the stripe modulus 5 and phase 2
- Sub-module bkg_tile_mask is a combinational (u, v, pat) → mask function, parametrised by TILE_LOG2. It is instantiated in stage 2. The top level holds the shadow registers, scroll counters and pipeline.

## Test plan
- Default pattern after reset: release rst_n, present px=2, py=0, pix_valid=1 → 2 cycles later col=110, col_valid=1. Then px=3, py=0 → col=000.
- Scroll step: frame_start with scroll_en=1, dx=+1, dy=0; then px=1, py=0 → sx=1, u=2 → col=110.
- Negative wrap: from sx=0 apply dx=-1 → sx=15. Then px=3, py=0 → u=2 → col=110. Also apply dx=+7 twice from sx=12 → sx=10.
- Frame-boundary shadowing: set pat_sel=1, fg_col=011 with no frame_start → px=8, py=0 still yields STRIPE result 000. After frame_start → col=011 (u[3]=1, v[3]=0).
- Simultaneous event: frame_start and pixel px=2, py=0 in the same cycle with pat_sel=3, bg_col=101 → that pixel uses STRIPE/fg 110. The next pixel px=3 → SOLID → col=fg.
- Blanking and reset: with pix_valid=0 → col=0, col_valid=0. Asserting rst_n=0 mid-stream → col=0 and col_valid=0 within the same cycle. Post-release, sx=sy=0 and pat=STRIPE.
